hit_resolver: RTL and testbench

//  Arbitrates hit requests between the two fighters and owns both health registers.

---
 rtl/hit_resolver_pkg.sv | 25 ++
 rtl/hit_resolver_if.sv | 30 +++
 rtl/hit_resolver_stun.sv | 30 +++
 rtl/hit_resolver.sv | 113 +++++++++++
 tb/tb_hit_resolver.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/hit_resolver_pkg.sv
// Shared definitions for the hit resolver and the game-state FSM:
// round state encoding, health width, KO codes and saturating subtract.
package hit_resolver_pkg;

  localparam int unsigned HEALTH_W = 3;

  typedef enum logic [1:0] {
    S_DISARMED = 2'd0,
    S_ARMED    = 2'd1,
    S_KO       = 2'd2
  } state_t;

  // KO codes are {p2_ko, p1_ko}
  localparam logic [1:0] KO_NONE = 2'b00;
  localparam logic [1:0] KO_P1   = 2'b01;
  localparam logic [1:0] KO_P2   = 2'b10;
  localparam logic [1:0] KO_DRAW = 2'b11;

  // Health never wraps: any damage at or above the remaining health lands on 0
  function automatic logic [HEALTH_W-1:0] sat_sub(input logic [HEALTH_W-1:0] a,
                                                  input logic [HEALTH_W-1:0] b);
    return (b >= a) ? '0 : (a - b);
  endfunction

endpackage

// File: rtl/hit_resolver_if.sv
// Bus between the game controller / hitbox logic (master) and the hit
// resolver (slave): per-frame requests in, health/stun/KO status out.
interface hit_resolver_if;
  import hit_resolver_pkg::*;

  logic                round_start;
  logic                fight_active;
  logic                p1_hit_req;
  logic                p2_hit_req;
  logic                p1_blocking;
  logic                p2_blocking;
  logic [HEALTH_W-1:0] player1_health;
  logic [HEALTH_W-1:0] player2_health;
  logic                p1_stunned;
  logic                p2_stunned;
  logic                p1_damaged;
  logic                p2_damaged;
  logic [1:0]          ko;

  modport master (
    output round_start, fight_active, p1_hit_req, p2_hit_req, p1_blocking, p2_blocking,
    input  player1_health, player2_health, p1_stunned, p2_stunned, p1_damaged, p2_damaged, ko
  );

  modport slave (
    input  round_start, fight_active, p1_hit_req, p2_hit_req, p1_blocking, p2_blocking,
    output player1_health, player2_health, p1_stunned, p2_stunned, p1_damaged, p2_damaged, ko
  );

endinterface

// File: rtl/hit_resolver_stun.sv
// stun_timer: per-player invulnerability window. A load starts a
// STUN_FRAMES-cycle window beginning the cycle after the load; clear
// (round restart) cancels it.
module stun_timer #(
  parameter int unsigned STUN_W      = 6,
  parameter int unsigned STUN_FRAMES = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_load,
  output logic o_active
);

  logic [STUN_W-1:0] r_count;

  // Load on accepted hit, otherwise count down to zero and hold
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= STUN_W'(STUN_FRAMES);
    end else if (r_count != '0) begin
      r_count <= r_count - STUN_W'(1);
    end
  end

  assign o_active = (r_count != '0);

endmodule

// File: rtl/hit_resolver.sv
// hit_resolver: accepts/rejects each fighter's hit request per frame, owns
// both health registers, starts stun windows and flags KO/draw.
// Optional feature macro: HIT_CHIP_DAMAGE_EN (blocked hits deal DMG_CHIP;
// when undefined a blocked hit deals no damage but still stuns).
module hit_resolver
  import hit_resolver_pkg::*;
#(
  parameter int unsigned HEALTH_MAX  = 5,
  parameter int unsigned DMG_HIT     = 2,
  parameter int unsigned DMG_CHIP    = 1,
  parameter int unsigned STUN_FRAMES = 30,
  parameter int unsigned STUN_W      = 6
) (
  input  logic           clk,
  input  logic           reset,
  hit_resolver_if.slave  bus
);

  localparam logic [HEALTH_W-1:0] L_HMAX = HEALTH_W'(HEALTH_MAX);
  localparam logic [HEALTH_W-1:0] L_HIT  = HEALTH_W'(DMG_HIT);
`ifdef HIT_CHIP_DAMAGE_EN
  localparam logic [HEALTH_W-1:0] L_BLOCKED = HEALTH_W'(DMG_CHIP);
`else
  localparam logic [HEALTH_W-1:0] L_BLOCKED = '0;
`endif

  state_t              r_state;
  logic [HEALTH_W-1:0] r_p1_health;
  logic [HEALTH_W-1:0] r_p2_health;
  logic                r_p1_damaged;
  logic                r_p2_damaged;
  logic [1:0]          r_ko;

  logic                w_p1_stunned;
  logic                w_p2_stunned;
  logic                w_open;
  logic                w_p1_acc;
  logic                w_p2_acc;
  logic [HEALTH_W-1:0] w_p1_dmg;
  logic [HEALTH_W-1:0] w_p2_dmg;
  logic [HEALTH_W-1:0] w_p1_next;
  logic [HEALTH_W-1:0] w_p2_next;

  // A hit lands only when the round is live and neither fighter is stunned;
  // round_start discards any same-cycle request
  always_comb begin
    w_open    = (r_state == S_ARMED) && !bus.round_start && bus.fight_active
                && !w_p1_stunned && !w_p2_stunned;
    w_p1_acc  = w_open && bus.p1_hit_req;
    w_p2_acc  = w_open && bus.p2_hit_req;
    w_p1_dmg  = bus.p1_blocking ? L_BLOCKED : L_HIT;
    w_p2_dmg  = bus.p2_blocking ? L_BLOCKED : L_HIT;
    w_p1_next = w_p2_acc ? sat_sub(r_p1_health, w_p1_dmg) : r_p1_health;
    w_p2_next = w_p1_acc ? sat_sub(r_p2_health, w_p2_dmg) : r_p2_health;
  end

  // Round FSM with registered health, damage pulses and KO flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_DISARMED;
      r_p1_health  <= L_HMAX;
      r_p2_health  <= L_HMAX;
      r_p1_damaged <= 1'b0;
      r_p2_damaged <= 1'b0;
      r_ko         <= KO_NONE;
    end else if (bus.round_start) begin
      r_state      <= S_ARMED;
      r_p1_health  <= L_HMAX;
      r_p2_health  <= L_HMAX;
      r_p1_damaged <= 1'b0;
      r_p2_damaged <= 1'b0;
      r_ko         <= KO_NONE;
    end else begin
      // Next health equals current outside S_ARMED, so the pulses stay low there
      r_p1_damaged <= (w_p1_next != r_p1_health);
      r_p2_damaged <= (w_p2_next != r_p2_health);
      if (r_state == S_ARMED) begin
        r_p1_health <= w_p1_next;
        r_p2_health <= w_p2_next;
        r_ko        <= {w_p2_next == '0, w_p1_next == '0};
        if ((w_p1_next == '0) || (w_p2_next == '0)) begin
          r_state <= S_KO;
        end
      end
    end
  end

  // P1 is stunned by P2's accepted hit and vice versa
  stun_timer #(.STUN_W(STUN_W), .STUN_FRAMES(STUN_FRAMES)) u_p1_stun (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (bus.round_start),
    .i_load   (w_p2_acc),
    .o_active (w_p1_stunned)
  );

  stun_timer #(.STUN_W(STUN_W), .STUN_FRAMES(STUN_FRAMES)) u_p2_stun (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (bus.round_start),
    .i_load   (w_p1_acc),
    .o_active (w_p2_stunned)
  );

  assign bus.player1_health = r_p1_health;
  assign bus.player2_health = r_p2_health;
  assign bus.p1_stunned     = w_p1_stunned;
  assign bus.p2_stunned     = w_p2_stunned;
  assign bus.p1_damaged     = r_p1_damaged;
  assign bus.p2_damaged     = r_p2_damaged;
  assign bus.ko             = r_ko;

endmodule

// File: tb/tb_hit_resolver.sv
// Testbench for hit_resolver: directed scenarios plus randomized frames,
// checked by a scoreboard fed from a behavioural round model.
module tb_hit_resolver;

  localparam int HMAX = 5;
  localparam int HIT  = 2;
  localparam int STUN = 30;
`ifdef HIT_CHIP_DAMAGE_EN
  localparam int CHIP = 1;
`else
  localparam int CHIP = 0;
`endif

  typedef struct {
    int       h1;
    int       h2;
    bit       s1;
    bit       s2;
    bit       d1;
    bit       d2;
    bit [1:0] ko;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hit_resolver_if bus ();

  hit_resolver #(
    .HEALTH_MAX  (HMAX),
    .DMG_HIT     (HIT),
    .DMG_CHIP    (1),
    .STUN_FRAMES (STUN),
    .STUN_W      (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  exp_t q[$];

  // Model: health per player, whether a round was ever started, and the
  // sampling-edge index at which each player was last hit (stun origin).
  int     m_h1, m_h2;
  bit     m_started;
  longint m_e;
  longint m_a1, m_a2;

  // Stun output is high for STUN edges starting at the accepting edge
  function automatic bit stunned_after(longint a, longint e);
    return (e >= a) && ((e - a) < STUN);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one frame's inputs and push the expected post-edge outputs
  task automatic step(input bit rs, input bit fa, input bit r1, input bit r2,
                      input bit b1, input bit b2);
    exp_t x;
    bit st1, st2, live, acc1, acc2;
    int o1, o2;
    @(negedge clk);
    bus.round_start  = rs;
    bus.fight_active = fa;
    bus.p1_hit_req   = r1;
    bus.p2_hit_req   = r2;
    bus.p1_blocking  = b1;
    bus.p2_blocking  = b2;
    st1 = stunned_after(m_a1, m_e - 1);
    st2 = stunned_after(m_a2, m_e - 1);
    x.d1 = 1'b0;
    x.d2 = 1'b0;
    if (rs) begin
      m_h1 = HMAX; m_h2 = HMAX; m_started = 1'b1;
      m_a1 = -1000; m_a2 = -1000;
    end else begin
      live = m_started && (m_h1 > 0) && (m_h2 > 0);
      acc1 = live && fa && r1 && !st1 && !st2;
      acc2 = live && fa && r2 && !st1 && !st2;
      o1 = m_h1; o2 = m_h2;
      if (acc1) begin
        m_h2 = m_h2 - (b2 ? CHIP : HIT);
        if (m_h2 < 0) m_h2 = 0;
        m_a2 = m_e;
      end
      if (acc2) begin
        m_h1 = m_h1 - (b1 ? CHIP : HIT);
        if (m_h1 < 0) m_h1 = 0;
        m_a1 = m_e;
      end
      x.d1 = (m_h1 < o1);
      x.d2 = (m_h2 < o2);
    end
    x.h1 = m_h1;
    x.h2 = m_h2;
    x.s1 = stunned_after(m_a1, m_e);
    x.s2 = stunned_after(m_a2, m_e);
    x.ko = {m_h2 == 0, m_h1 == 0};
    q.push_back(x);
    m_e++;
  endtask

  // Wait for the edge that samples the last step; monitor has already run
  task automatic peek();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected frame per edge, compared just after the edge
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        n_tests++;
        if (int'(bus.player1_health) != x.h1 || int'(bus.player2_health) != x.h2 ||
            bus.p1_stunned != x.s1 || bus.p2_stunned != x.s2 ||
            bus.p1_damaged != x.d1 || bus.p2_damaged != x.d2 || bus.ko != x.ko) begin
          n_fail++;
          $display("FAIL scoreboard t=%0t: got h=%0d/%0d st=%b%b dmg=%b%b ko=%b expected h=%0d/%0d st=%b%b dmg=%b%b ko=%b",
                   $time, bus.player1_health, bus.player2_health, bus.p1_stunned, bus.p2_stunned,
                   bus.p1_damaged, bus.p2_damaged, bus.ko,
                   x.h1, x.h2, x.s1, x.s2, x.d1, x.d2, x.ko);
        end
      end
    end
  end

  initial begin
    reset            = 1'b1;
    bus.round_start  = 1'b0;
    bus.fight_active = 1'b0;
    bus.p1_hit_req   = 1'b0;
    bus.p2_hit_req   = 1'b0;
    bus.p1_blocking  = 1'b0;
    bus.p2_blocking  = 1'b0;
    m_h1 = HMAX; m_h2 = HMAX; m_started = 1'b0;
    m_e = 0; m_a1 = -1000; m_a2 = -1000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_h1", int'(bus.player1_health), HMAX);
    chk("reset_h2", int'(bus.player2_health), HMAX);
    chk("reset_ko", int'(bus.ko), 0);
    chk("reset_stun", int'({bus.p1_stunned, bus.p2_stunned}), 0);
    chk("reset_dmg", int'({bus.p1_damaged, bus.p2_damaged}), 0);

    // Disarmed: hit ignored
    step(0, 1, 1, 0, 0, 0); peek();
    chk("disarmed_h2", int'(bus.player2_health), HMAX);

    // Round start
    step(1, 0, 0, 0, 0, 0); peek();
    chk("start_h1", int'(bus.player1_health), HMAX);
    chk("start_h2", int'(bus.player2_health), HMAX);
    chk("start_ko", int'(bus.ko), 0);

    // Single unblocked hit
    step(0, 1, 1, 0, 0, 0); peek();
    chk("hit_h2", int'(bus.player2_health), 3);
    chk("hit_dmg", int'(bus.p2_damaged), 1);
    chk("hit_stun", int'(bus.p2_stunned), 1);
    step(0, 1, 0, 0, 0, 0); peek();
    chk("hit_pulse_end", int'(bus.p2_damaged), 0);
    repeat (40) step(0, 1, 0, 0, 0, 0);

    // Held request: re-hits every STUN+1 frames until KO
    step(1, 1, 0, 0, 0, 0);
    repeat (100) step(0, 1, 1, 0, 0, 0);
    peek();
    chk("held_h2", int'(bus.player2_health), 0);
    chk("held_ko", int'(bus.ko), 2);
    chk("held_h1", int'(bus.player1_health), HMAX);

    // Trade down to a draw
    step(1, 1, 0, 0, 0, 0);
    repeat (70) step(0, 1, 1, 1, 0, 0);
    peek();
    chk("draw_ko", int'(bus.ko), 3);
    chk("draw_h", int'({bus.player1_health, bus.player2_health}), 0);

    // Restart from KO
    step(1, 1, 0, 0, 0, 0); peek();
    chk("restart_h1", int'(bus.player1_health), HMAX);
    chk("restart_ko", int'(bus.ko), 0);

    // Blocked hit
    step(0, 1, 1, 0, 0, 1); peek();
    chk("block_h2", int'(bus.player2_health), HMAX - CHIP);
    chk("block_stun", int'(bus.p2_stunned), 1);
    chk("block_dmg", int'(bus.p2_damaged), (CHIP > 0) ? 1 : 0);
    repeat (35) step(0, 1, 0, 0, 0, 0);

    // fight_active low, then round_start coinciding with hits
    step(0, 0, 1, 0, 0, 0); peek();
    chk("inactive_h2", int'(bus.player2_health), HMAX - CHIP);
    chk("inactive_stun", int'(bus.p2_stunned), 0);
    step(1, 1, 1, 1, 0, 0); peek();
    chk("rs_hit_h", int'({bus.player1_health, bus.player2_health}), (HMAX << 3) | HMAX);
    chk("rs_hit_stun", int'({bus.p1_stunned, bus.p2_stunned}), 0);

    // Randomized frames
    repeat (4000) begin
      step($urandom_range(0, 149) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    repeat (2) @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
